// File: rtl/ps2_key_fifo.sv
// PS/2 scan-code set 2 front end: prefix/break/modifier tracking, US-ASCII translation,
// and a first-word-fall-through key FIFO read by the MCU.
module ps2_key_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     scan_valid,
  input  logic [7:0]               scan_byte,
  input  logic                     pop,
  input  logic                     clr_ovf,
  output logic [7:0]               key_data,
  output logic                     key_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     shift_state,
  output logic                     caps_state
);
  // state     | meaning
  // IDLE      | expecting make code or prefix
  // BREAK     | F0 seen, next byte is a release
  // EXT       | E0 seen, next byte is an extended make or F0
  // EXT_BREAK | E0 F0 seen, next byte is consumed
  // SKIP      | swallowing the Pause sequence, skip_cnt bytes left
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [2:0] ST_IDLE = 3'd0, ST_BREAK = 3'd1, ST_EXT = 3'd2,
                         ST_EXT_BREAK = 3'd3, ST_SKIP = 3'd4;

  logic [2:0] state, nxt_state;
  logic [2:0] skip_cnt, nxt_cnt;
  logic shift_l, shift_r, caps, caps_held;
  logic nxt_shl, nxt_shr, nxt_caps, nxt_held;
  logic push_en;
  logic [7:0] push_code;
  logic pipe_valid;
  logic [7:0] pipe_data;
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic ignored, accept, do_push, do_pop;
  logic [1:0] kind;
  logic [7:0] base, alt, mk_code, ext_code;
  logic ext_hit;

  assign ignored = (scan_byte == 8'h00) || (scan_byte == 8'hAA) || (scan_byte == 8'hEE) ||
                   (scan_byte == 8'hFA) || (scan_byte == 8'hFE) || (scan_byte == 8'hFF);
  assign accept = scan_valid && !ignored;

  // kind: 0 unmapped, 1 fixed code, 2 letter, 3 digit (alt holds the shifted symbol)
  always_comb begin
    kind = 2'd0; base = 8'h00; alt = 8'h00;
    case (scan_byte)
      8'h1C: {kind, base} = {2'd2, 8'h61};  8'h32: {kind, base} = {2'd2, 8'h62};
      8'h21: {kind, base} = {2'd2, 8'h63};  8'h23: {kind, base} = {2'd2, 8'h64};
      8'h24: {kind, base} = {2'd2, 8'h65};  8'h2B: {kind, base} = {2'd2, 8'h66};
      8'h34: {kind, base} = {2'd2, 8'h67};  8'h33: {kind, base} = {2'd2, 8'h68};
      8'h43: {kind, base} = {2'd2, 8'h69};  8'h3B: {kind, base} = {2'd2, 8'h6A};
      8'h42: {kind, base} = {2'd2, 8'h6B};  8'h4B: {kind, base} = {2'd2, 8'h6C};
      8'h3A: {kind, base} = {2'd2, 8'h6D};  8'h31: {kind, base} = {2'd2, 8'h6E};
      8'h44: {kind, base} = {2'd2, 8'h6F};  8'h4D: {kind, base} = {2'd2, 8'h70};
      8'h15: {kind, base} = {2'd2, 8'h71};  8'h2D: {kind, base} = {2'd2, 8'h72};
      8'h1B: {kind, base} = {2'd2, 8'h73};  8'h2C: {kind, base} = {2'd2, 8'h74};
      8'h3C: {kind, base} = {2'd2, 8'h75};  8'h2A: {kind, base} = {2'd2, 8'h76};
      8'h1D: {kind, base} = {2'd2, 8'h77};  8'h22: {kind, base} = {2'd2, 8'h78};
      8'h35: {kind, base} = {2'd2, 8'h79};  8'h1A: {kind, base} = {2'd2, 8'h7A};
      8'h16: {kind, base, alt} = {2'd3, 8'h31, 8'h21};
      8'h1E: {kind, base, alt} = {2'd3, 8'h32, 8'h40};
      8'h26: {kind, base, alt} = {2'd3, 8'h33, 8'h23};
      8'h25: {kind, base, alt} = {2'd3, 8'h34, 8'h24};
      8'h2E: {kind, base, alt} = {2'd3, 8'h35, 8'h25};
      8'h36: {kind, base, alt} = {2'd3, 8'h36, 8'h5E};
      8'h3D: {kind, base, alt} = {2'd3, 8'h37, 8'h26};
      8'h3E: {kind, base, alt} = {2'd3, 8'h38, 8'h2A};
      8'h46: {kind, base, alt} = {2'd3, 8'h39, 8'h28};
      8'h45: {kind, base, alt} = {2'd3, 8'h30, 8'h29};
      8'h29: {kind, base} = {2'd1, 8'h20};  8'h5A: {kind, base} = {2'd1, 8'h0D};
      8'h66: {kind, base} = {2'd1, 8'h08};  8'h76: {kind, base} = {2'd1, 8'h1B};
      8'h0D: {kind, base} = {2'd1, 8'h09};
      default: ;
    endcase
  end

  always_comb begin
    mk_code = base;
    if (kind == 2'd2 && ((shift_l | shift_r) ^ caps)) mk_code = base - 8'h20;
    else if (kind == 2'd3 && (shift_l | shift_r))     mk_code = alt;
  end

  always_comb begin
    ext_hit = 1'b1; ext_code = 8'h00;
    case (scan_byte)
      8'h75: ext_code = 8'h11;
      8'h72: ext_code = 8'h12;
      8'h6B: ext_code = 8'h13;
      8'h74: ext_code = 8'h14;
      default: ext_hit = 1'b0;
    endcase
  end

  always_comb begin
    nxt_state = state; nxt_cnt = skip_cnt;
    nxt_shl = shift_l; nxt_shr = shift_r; nxt_caps = caps; nxt_held = caps_held;
    push_en = 1'b0; push_code = mk_code;
    if (accept) begin
      case (state)
        ST_IDLE:
          if (scan_byte == 8'hF0)      nxt_state = ST_BREAK;
          else if (scan_byte == 8'hE0) nxt_state = ST_EXT;
          else if (scan_byte == 8'hE1) begin
            nxt_state = ST_SKIP;
            nxt_cnt   = 3'd7;
          end else begin
            case (scan_byte)
              8'h12: nxt_shl = 1'b1;
              8'h59: nxt_shr = 1'b1;
              8'h58: begin
                if (!caps_held) nxt_caps = ~caps;
                nxt_held = 1'b1;
              end
              default: push_en = (kind != 2'd0);
            endcase
          end
        ST_BREAK:
          if (scan_byte == 8'hE0) nxt_state = ST_EXT;
          else begin
            nxt_state = ST_IDLE;
            case (scan_byte)
              8'h12: nxt_shl = 1'b0;
              8'h59: nxt_shr = 1'b0;
              8'h58: nxt_held = 1'b0;
              default: ;
            endcase
          end
        ST_EXT:
          if (scan_byte == 8'hF0) nxt_state = ST_EXT_BREAK;
          else begin
            nxt_state = ST_IDLE;
            push_en   = ext_hit;
            push_code = ext_code;
          end
        ST_EXT_BREAK: nxt_state = (scan_byte == 8'hE0) ? ST_EXT : ST_IDLE;
        ST_SKIP: begin
          nxt_cnt = skip_cnt - 3'd1;
          if (skip_cnt == 3'd1) nxt_state = ST_IDLE;
        end
        default: nxt_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE; skip_cnt <= 3'd0;
      shift_l <= 1'b0; shift_r <= 1'b0; caps <= 1'b0; caps_held <= 1'b0;
      pipe_valid <= 1'b0; pipe_data <= 8'h00;
    end else begin
      state <= nxt_state; skip_cnt <= nxt_cnt;
      shift_l <= nxt_shl; shift_r <= nxt_shr; caps <= nxt_caps; caps_held <= nxt_held;
      pipe_valid <= push_en;
      pipe_data  <= push_code;
    end
  end

  // A pop on a full FIFO frees the slot the same cycle, so the push is still taken.
  assign do_pop  = pop && (count != '0);
  assign do_push = pipe_valid && ((count != FULL_CNT) || do_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0; rd_ptr <= '0; count <= '0; overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (pipe_valid && !do_push) overflow <= 1'b1;
      else if (clr_ovf)           overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= pipe_data;
  end

  assign key_valid   = (count != '0);
  assign key_data    = key_valid ? mem[rd_ptr] : 8'h00;
  assign shift_state = shift_l | shift_r;
  assign caps_state  = caps;
endmodule
